// File: rtl/seven_seg_scanner_pkg.sv
// Shared definitions for the seven-segment digit scanner: FSM state encoding,
// one-hot digit strobe constants and the largest displayable BCD nibble.
package seven_seg_scanner_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_GAP  = 2'd1,
    ST_SHOW = 2'd2
  } scan_state_t;

  localparam logic [3:0] DIGIT_OFF = 4'b0000;
  localparam logic [3:0] DIGIT_0   = 4'b0001;
  localparam logic [3:0] DIGIT_1   = 4'b0010;
  localparam logic [3:0] DIGIT_2   = 4'b0100;
  localparam logic [3:0] DIGIT_3   = 4'b1000;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Map a digit index to its strobe; index 0 is the rightmost digit.
  function automatic logic [3:0] digit_onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    return DIGIT_0;
      2'd1:    return DIGIT_1;
      2'd2:    return DIGIT_2;
      default: return DIGIT_3;
    endcase
  endfunction

endpackage

// File: rtl/seven_seg_scanner_prescaler.sv
// Slot timer for the scanner: counts the cycles of one digit slot and flags
// the end of the anti-ghosting gap, the last slot cycle and the cycle before it.
module scan_prescaler #(
  parameter int SCAN_DIV   = 100000,
  parameter int GAP_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic gap_done,
  output logic slot_done,
  output logic near_end
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] count;

  assign gap_done  = run && (count == CNT_W'(GAP_CYCLES - 1));
  assign slot_done = run && (count == CNT_W'(SCAN_DIV - 1));
  assign near_end  = run && (count == CNT_W'(SCAN_DIV - 2));

  // Free-run through one slot while scanning, wrap at the slot end, hold at zero when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!run || slot_done) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed 4-digit seven-segment scanner: strobes one digit per slot with
// an all-off gap at the start of each slot, supports leading-zero blanking,
// blanks non-BCD nibbles and only accepts new values at slot boundaries.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int GAP_CYCLES = 1000
) (
  input  logic        CLK100MHZ,
  input  logic        ck_rst,
  input  logic        en,
  input  logic        lz_blank,
  input  logic        load_valid,
  input  logic [15:0] load_value,
  output logic        load_ready,
  output logic [3:0]  digits,
  output logic [3:0]  bcd,
  output logic        slot_tick
);

  scan_state_t state;
  logic [1:0]  index;
  logic [15:0] shadow;
  logic        gap_done;
  logic        slot_done;
  logic        near_end;
  logic [3:0]  show_nibble;
  logic        lead_zero;
  logic        show_blank;

  scan_prescaler #(
    .SCAN_DIV   (SCAN_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_prescaler (
    .clk       (CLK100MHZ),
    .rst_n     (ck_rst),
    .run       (state != ST_OFF),
    .gap_done  (gap_done),
    .slot_done (slot_done),
    .near_end  (near_end)
  );

  // Decide what the upcoming SHOW phase displays for the current digit index.
  always_comb begin
    show_nibble = shadow[{index, 2'b00} +: 4];
    lead_zero   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if ((i >= int'(index)) && (shadow[i*4 +: 4] != 4'h0)) begin
        lead_zero = 1'b0;
      end
    end
    show_blank = (show_nibble > BCD_MAX) || (lz_blank && (index != 2'd0) && lead_zero);
  end

  // Capture a new display value only at a slot boundary or while the display is off.
  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      shadow <= 16'h0000;
    end else if (load_valid && load_ready) begin
      shadow <= load_value;
    end
  end

  // Scan FSM with registered strobe, nibble and handshake outputs; ready and tick are looked ahead one cycle.
  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      state      <= ST_OFF;
      index      <= 2'd0;
      digits     <= DIGIT_OFF;
      bcd        <= 4'h0;
      load_ready <= 1'b0;
      slot_tick  <= 1'b0;
    end else begin
      load_ready <= 1'b0;
      slot_tick  <= 1'b0;
      if (!en) begin
        state      <= ST_OFF;
        index      <= 2'd0;
        digits     <= DIGIT_OFF;
        bcd        <= 4'h0;
        load_ready <= 1'b1;
      end else begin
        if (near_end) begin
          load_ready <= 1'b1;
          slot_tick  <= 1'b1;
        end
        case (state)
          ST_OFF: begin
            state  <= ST_GAP;
            index  <= 2'd0;
            digits <= DIGIT_OFF;
            bcd    <= 4'h0;
          end
          ST_GAP: begin
            if (gap_done) begin
              state <= ST_SHOW;
              if (show_blank) begin
                digits <= DIGIT_OFF;
                bcd    <= 4'h0;
              end else begin
                digits <= digit_onehot(index);
                bcd    <= show_nibble;
              end
            end
          end
          ST_SHOW: begin
            if (slot_done) begin
              state  <= ST_GAP;
              index  <= index + 2'd1;
              digits <= DIGIT_OFF;
              bcd    <= 4'h0;
            end
          end
          default: begin
            state  <= ST_OFF;
            digits <= DIGIT_OFF;
            bcd    <= 4'h0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: each enabled slot is summarised
// (length, gap length, strobe, nibble, glitches) and compared on slot_tick
// against the expectation queued when the stimulus was applied.
module tb_seven_seg_scanner;

  localparam int SCAN_DIV   = 10;
  localparam int GAP_CYCLES = 2;

  logic        CLK100MHZ = 1'b0;
  logic        ck_rst;
  logic        en;
  logic        lz_blank;
  logic        load_valid;
  logic [15:0] load_value;
  logic        load_ready;
  logic [3:0]  digits;
  logic [3:0]  bcd;
  logic        slot_tick;

  int vectors     = 0;
  int miscompares = 0;
  int ticks       = 0;

  logic [23:0] exp_q[$];
  logic [15:0] exp_value;
  logic        exp_lz;
  int          exp_idx;

  logic        en_prev = 1'b0;
  logic [7:0]  obs_len;
  logic [7:0]  obs_lit;
  logic [7:0]  obs_first;
  logic [3:0]  obs_dig;
  logic [3:0]  obs_bcd;
  logic        obs_bad;

  seven_seg_scanner #(
    .SCAN_DIV   (SCAN_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .CLK100MHZ  (CLK100MHZ),
    .ck_rst     (ck_rst),
    .en         (en),
    .lz_blank   (lz_blank),
    .load_valid (load_valid),
    .load_value (load_value),
    .load_ready (load_ready),
    .digits     (digits),
    .bcd        (bcd),
    .slot_tick  (slot_tick)
  );

  // 100 MHz clock
  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected slot summary {lit cycles, first lit cycle, strobe, nibble}
  function automatic logic [23:0] expected_shape(input logic [15:0] v, input logic lz, input int idx);
    logic [15:0] upper;
    logic [3:0]  nib;
    upper = v >> (4 * idx);
    nib   = upper[3:0];
    if (nib > 4'd9 || (lz && idx != 0 && upper == 16'h0000))
      return {8'd0, 8'hFF, 8'h00};
    return {8'(SCAN_DIV - GAP_CYCLES), 8'(GAP_CYCLES), 4'(1 << idx), nib};
  endfunction

  task automatic clear_obs();
    obs_len   = 8'd0;
    obs_lit   = 8'd0;
    obs_first = 8'hFF;
    obs_dig   = 4'h0;
    obs_bcd   = 4'h0;
    obs_bad   = 1'b0;
  endtask

  // Fold one cycle's outputs into the running slot summary; score it on slot_tick
  task automatic sample_slot();
    logic [23:0] expv;
    if (!ck_rst || !en_prev) begin
      clear_obs();
    end else begin
      obs_len = obs_len + 8'd1;
      if (digits != 4'b0000) begin
        if (obs_lit == 8'd0) begin
          obs_first = obs_len - 8'd1;
          obs_dig   = digits;
          obs_bcd   = bcd;
        end else if (digits != obs_dig || bcd != obs_bcd) begin
          obs_bad = 1'b1;
        end
        obs_lit = obs_lit + 8'd1;
      end else if (bcd != 4'h0 || obs_lit != 8'd0) begin
        obs_bad = 1'b1;
      end
      if (!$onehot0(digits)) obs_bad = 1'b1;
      if (slot_tick) begin
        if (exp_q.size() != 0) expv = exp_q.pop_front();
        else expv = '1;
        checkOutput("slot_len", 32'(obs_len), SCAN_DIV);
        checkOutput("slot_shape", {8'h00, obs_lit, obs_first, obs_dig, obs_bcd}, {8'h00, expv});
        checkOutput("slot_clean", 32'(obs_bad), 0);
        ticks++;
        clear_obs();
      end
    end
    en_prev = en;
  endtask

  // Sample the current cycle mid-period, then step to just after the next rising edge
  task automatic tick();
    @(negedge CLK100MHZ);
    sample_slot();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic wait_ticks(input int target, input int budget);
    int c = 0;
    while (ticks < target && c < budget) begin
      tick();
      c++;
    end
    checkOutput("slot_tick_count", ticks, target);
  endtask

  // Queue the next n slots from the bench's own value model and let them run
  task automatic run_slots(input int n);
    int target;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(expected_shape(exp_value, exp_lz, exp_idx));
      exp_idx = (exp_idx + 1) % 4;
    end
    target = ticks + n;
    wait_ticks(target, n * SCAN_DIV + 20);
  endtask

  // Turn the display off, load a value while off, then re-enable scanning
  task automatic applyStimulus(input logic [15:0] v, input logic lz);
    en = 1'b0;
    tick();
    checkOutput("ready_in_off", 32'(load_ready), 1);
    load_valid = 1'b1;
    load_value = v;
    tick();
    load_valid = 1'b0;
    exp_value  = v;
    exp_lz     = lz;
    lz_blank   = lz;
    exp_idx    = 0;
    en         = 1'b1;
  endtask

  initial begin
    clear_obs();
    ck_rst     = 1'b0;
    en         = 1'b0;
    lz_blank   = 1'b0;
    load_valid = 1'b0;
    load_value = 16'h0000;
    exp_value  = 16'h0000;
    exp_lz     = 1'b0;
    exp_idx    = 0;

    repeat (3) @(posedge CLK100MHZ);
    #1;
    checkOutput("reset_digits", 32'(digits), 0);
    checkOutput("reset_bcd", 32'(bcd), 0);
    checkOutput("reset_ready", 32'(load_ready), 0);
    checkOutput("reset_tick", 32'(slot_tick), 0);
    ck_rst = 1'b1;
    tick();
    checkOutput("ready_after_reset", 32'(load_ready), 1);

    // Basic scan order including the 3 -> 0 wrap
    applyStimulus(16'h1234, 1'b0);
    run_slots(5);

    // Leading-zero suppression, including the all-zero value
    applyStimulus(16'h0050, 1'b1);
    run_slots(4);
    applyStimulus(16'h0000, 1'b1);
    run_slots(4);

    // Non-BCD nibble blanks its slot
    applyStimulus(16'h0A00, 1'b0);
    run_slots(4);

    // Load offered mid-SHOW is held off until slot_tick, then shown next slot
    applyStimulus(16'h1234, 1'b0);
    run_slots(1);
    begin
      int target;
      exp_q.push_back(expected_shape(16'h1234, 1'b0, 1));
      exp_q.push_back(expected_shape(16'h5678, 1'b0, 2));
      exp_q.push_back(expected_shape(16'h5678, 1'b0, 3));
      target = ticks + 3;
      for (int c = 0; c < SCAN_DIV; c++) begin
        if (c == 4) begin
          load_valid = 1'b1;
          load_value = 16'h5678;
        end
        if (c >= 4) begin
          checkOutput("load_ready_window", 32'(load_ready), 32'(c == SCAN_DIV - 1));
          checkOutput("slot_tick_window", 32'(slot_tick), 32'(c == SCAN_DIV - 1));
        end
        tick();
      end
      load_valid = 1'b0;
      wait_ticks(target, 3 * SCAN_DIV + 20);
      exp_value = 16'h5678;
      exp_idx   = 0;
    end

    // Dropping enable mid-SHOW blanks next cycle; re-enable restarts at digit 0
    repeat (5) tick();
    checkOutput("lit_before_drop", {digits, bcd}, {4'b0001, 4'h8});
    en = 1'b0;
    tick();
    checkOutput("off_after_en_drop", {digits, bcd}, 0);
    en      = 1'b1;
    exp_idx = 0;
    run_slots(2);

    // Asynchronous reset mid-SHOW blanks without a clock edge and clears the value
    repeat (5) tick();
    #2;
    ck_rst = 1'b0;
    en     = 1'b0;
    #1;
    checkOutput("async_reset_blank", {digits, bcd, load_ready, slot_tick}, 0);
    tick();
    ck_rst    = 1'b1;
    en        = 1'b1;
    lz_blank  = 1'b0;
    exp_lz    = 1'b0;
    exp_value = 16'h0000;
    exp_idx   = 0;
    run_slots(4);

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 100000, SHALL set the clock cycles per digit time slot, SHOW plus GAP (1 ms at 100 MHz); legal range 4..2^20.
REQ-002 Parameter GAP_CYCLES, default 1000, SHALL set the all-off anti-ghosting cycles at the start of each slot; legal range 1..SCAN_DIV-2.
REQ-003 CLK100MHZ  input  1  sole clock; all state changes on its rising edge.
REQ-004 ck_rst  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  scan enable; 0 forces display off.
REQ-006 lz_blank  input  1  leading-zero suppression enable.
REQ-007 load_valid  input  1  new 4-digit BCD value offered.
REQ-008 load_value  input  16  BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-009 load_ready  output  1  scanner accepts load_value this cycle.
REQ-010 digits  output  4  one-hot digit strobe (4'b0001 = digit 0 … 4'b1000 = digit 3); 4'b0000 = all off; drives the display decoder's digit input.
REQ-011 bcd  output  4  nibble for the strobed digit; 4'h0 when digits is 4'b0000.
REQ-012 slot_tick  output  1  one-cycle pulse on the last cycle of every slot.

Function
REQ-013 A load SHALL transfer on a cycle with load_valid=1 and load_ready=1; the scanner SHALL capture load_value into a 16-bit shadow register.
REQ-014 load_ready SHALL be 1 only in the last cycle of a slot (coincident with slot_tick) or while in OFF, so a value never changes mid-digit.
REQ-015 The FSM SHALL have states OFF, GAP and SHOW.
REQ-016 OFF SHALL output digits=4'b0000; on en=1 it SHALL go to GAP with digit index 0 and the slot counter cleared.
REQ-017 GAP SHALL last exactly GAP_CYCLES cycles with digits=4'b0000, then go to SHOW.
REQ-018 SHOW SHALL last SCAN_DIV-GAP_CYCLES cycles, driving digits=one-hot(index) and bcd=shadow nibble[index].
REQ-019 At the end of SHOW the index SHALL increment modulo 4 (3 wraps to 0) and the FSM SHALL return to GAP.
REQ-020 Slot period SHALL be exactly SCAN_DIV cycles and frame period exactly 4*SCAN_DIV cycles, with no drift.
REQ-021 A nibble > 9 SHALL blank that slot: digits=4'b0000 for the whole SHOW.
REQ-022 With lz_blank=1, a digit SHALL be blanked when it and all higher digits are 0; digit 0 SHALL never be blanked by suppression (value 0000 shows "0").
REQ-023 en falling to 0 SHALL force OFF on the next cycle, whatever the state; the shadow register SHALL be retained.
REQ-024 A load accepted in OFF SHALL take effect from the first slot after en rises.
REQ-025 A load accepted on a slot_tick SHALL be displayed from the very next slot.
REQ-026 The digits and bcd outputs SHALL be registered, with no combinational path from any input.
REQ-027 digits SHALL never have more than one bit set.

Reset
REQ-028 While ck_rst=0: state=OFF, index=0, slot counter=0, shadow=16'h0000, digits=4'b0000, bcd=4'h0, load_ready=0, slot_tick=0.
REQ-029 Reset assertion mid-slot SHALL blank digits immediately (asynchronously).
REQ-030 After ck_rst deasserts, the first clock SHALL evaluate en from OFF.

Structure
REQ-031 A shared package SHALL hold the state encoding (OFF, GAP, SHOW), the one-hot digit constants, DIGIT_OFF=4'b0000, and the BCD_MAX=9 constant.
REQ-032 The slot counter plus the GAP/SHOW phase decode SHALL be a sub-module, scan_prescaler (outputs gap_done, slot_done).

Verification
REQ-033 Reset, then en=1 with SCAN_DIV=10, GAP_CYCLES=2, value 16'h1234 -> digits 0000 for 2 cycles, then 0001 with bcd=4 for 8 cycles, then 0000 for 2 cycles, then 0010 with bcd=3, …; 4'b1000 is followed by 4'b0001.
REQ-034 lz_blank=1 with value 16'h0050 -> digits 3 and 2 off for their full slots, digit 1 shows 5, digit 0 shows 0; with value 16'h0000 only digit 0 is lit.
REQ-035 load_valid held high from mid-SHOW -> load_ready=1 only on the slot_tick cycle; the new value appears in the next slot; bcd is stable throughout the previous slot.
REQ-036 Value 16'h0A00 -> the digit 2 slot is all off; the other digits show 0 (lz_blank=0).
REQ-037 en dropped mid-SHOW -> digits=0000 on the next cycle; re-enable -> scan restarts at GAP for digit 0 with the same value.
REQ-038 ck_rst pulsed low mid-SHOW -> digits=0000 without a clock edge; shadow reads 0000 after release.
